// File: rtl/pe_grid_pkg.sv
// pe_grid_pkg: shared grid dimensions and scheduler state encoding
package pe_grid_pkg;
    localparam int ROWS   = 12;
    localparam int COLS   = 14;
    localparam int DATA_W = 16;
    localparam int ID_W   = 4;
    localparam int PSUM_W = 32;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        LOAD_I = 3'd2,
        DRAIN  = 3'd3,
        OUT    = 3'd4
    } sched_state_t;
endpackage

// File: rtl/pe_grid_scheduler_tag_sequencer.sv
// tag_sequencer: beat counter that presents the current tag and flags the beat reaching the limit
module tag_sequencer #(
    parameter int ID_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            adv,
    input  logic [ID_W-1:0] limit,
    output logic [ID_W-1:0] tag,
    output logic            last
);
    logic [ID_W-1:0] cnt_q, cnt_d;
    assign tag  = cnt_q;
    assign last = adv && (cnt_q == limit - 1'b1);
    // the final beat returns the count to zero so tags never reach the limit
    always_comb cnt_d = (clr || last) ? '0 : adv ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/pe_grid_scheduler.sv
// pe_grid_scheduler: sequences weight load, image passes, psum drain and output handshake for a PE grid
module pe_grid_scheduler #(
    parameter int ROWS      = pe_grid_pkg::ROWS,
    parameter int COLS      = pe_grid_pkg::COLS,
    parameter int DATA_W    = pe_grid_pkg::DATA_W,
    parameter int ID_W      = pe_grid_pkg::ID_W,
    parameter int DRAIN_CYC = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ID_W-1:0]   cfg_rows,
    input  logic [ID_W-1:0]   cfg_cols,
    input  logic [7:0]        cfg_passes,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    input  logic              w_valid,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_ready,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              i_ready,
    output logic [DATA_W-1:0] weight_val_in,
    output logic [ID_W-1:0]   tag_row,
    output logic              valid_y,
    output logic [DATA_W-1:0] image_val_in,
    output logic [ID_W-1:0]   tag_col,
    output logic              valid_x,
    output logic              psum_valid,
    input  logic              psum_ready
);
    import pe_grid_pkg::*;
    localparam logic [ID_W-1:0] ROWS_L     = ID_W'(ROWS);
    localparam logic [ID_W-1:0] COLS_L     = ID_W'(COLS);
    localparam logic [7:0]      DRAIN_LAST = 8'(DRAIN_CYC - 1);
    sched_state_t      state_q, state_d;
    logic [ID_W-1:0]   rows_q, rows_d, cols_q, cols_d;
    logic [7:0]        passes_q, passes_d, pass_q, pass_d, drain_q, drain_d;
    logic              busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
    logic              w_ready_q, w_ready_d, i_ready_q, i_ready_d, psum_valid_q, psum_valid_d;
    logic              valid_y_q, valid_y_d, valid_x_q, valid_x_d;
    logic [DATA_W-1:0] weight_q, weight_d, image_q, image_d;
    logic [ID_W-1:0]   tag_row_q, tag_row_d, tag_col_q, tag_col_d;
    logic              cfg_ok, start_ok, w_acc, i_acc, p_acc, row_last, col_last;
    logic [ID_W-1:0]   row_tag, col_tag;
    logic [7:0]        pass_inc;
    assign cfg_ok   = cfg_rows != '0 && cfg_rows <= ROWS_L && cfg_cols != '0 && cfg_cols <= COLS_L && cfg_passes != '0;
    assign start_ok = state_q == IDLE && start && cfg_ok;
    assign w_acc    = w_valid && w_ready_q;
    assign i_acc    = i_valid && i_ready_q;
    assign p_acc    = psum_valid_q && psum_ready;
    assign pass_inc = pass_q + 1'b1;
    tag_sequencer #(.ID_W(ID_W)) u_row_seq (
        .clk(clk), .rst(rst), .clr(start_ok), .adv(w_acc), .limit(rows_q), .tag(row_tag), .last(row_last)
    );
    tag_sequencer #(.ID_W(ID_W)) u_col_seq (
        .clk(clk), .rst(rst), .clr(start_ok), .adv(i_acc), .limit(cols_q), .tag(col_tag), .last(col_last)
    );
    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        passes_d  = passes_q;
        pass_d    = pass_q;
        drain_d   = drain_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (cfg_ok) begin
                    state_d  = LOAD_W;
                    rows_d   = cfg_rows;
                    cols_d   = cfg_cols;
                    passes_d = cfg_passes;
                    pass_d   = '0;
                    drain_d  = '0;
                end else cfg_err_d = 1'b1;
            end
            LOAD_W: state_d = row_last ? LOAD_I : LOAD_W;
            LOAD_I: begin
                state_d = col_last ? DRAIN : LOAD_I;
                drain_d = '0;
            end
            DRAIN: begin
                drain_d = drain_q + 1'b1;
                state_d = (drain_q == DRAIN_LAST) ? OUT : DRAIN;
            end
            OUT: if (p_acc) begin
                pass_d  = pass_inc;
                done_d  = pass_inc == passes_q;
                state_d = (pass_inc == passes_q) ? IDLE : LOAD_I;
            end
            default: state_d = IDLE;
        endcase
    end
    // handshake outputs are decoded from the next state so they are registered yet aligned with it
    assign busy_d       = state_d != IDLE;
    assign w_ready_d    = state_d == LOAD_W;
    assign i_ready_d    = state_d == LOAD_I;
    assign psum_valid_d = state_d == OUT;
    assign valid_y_d    = w_acc;
    assign weight_d     = w_acc ? w_data : '0;
    assign tag_row_d    = w_acc ? row_tag : '0;
    assign valid_x_d    = i_acc;
    assign image_d      = i_acc ? i_data : '0;
    assign tag_col_d    = i_acc ? col_tag : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rows_q       <= '0;
            cols_q       <= '0;
            passes_q     <= '0;
            pass_q       <= '0;
            drain_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            w_ready_q    <= 1'b0;
            i_ready_q    <= 1'b0;
            psum_valid_q <= 1'b0;
            valid_y_q    <= 1'b0;
            valid_x_q    <= 1'b0;
            weight_q     <= '0;
            image_q      <= '0;
            tag_row_q    <= '0;
            tag_col_q    <= '0;
        end else begin
            state_q      <= state_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
            passes_q     <= passes_d;
            pass_q       <= pass_d;
            drain_q      <= drain_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
            w_ready_q    <= w_ready_d;
            i_ready_q    <= i_ready_d;
            psum_valid_q <= psum_valid_d;
            valid_y_q    <= valid_y_d;
            valid_x_q    <= valid_x_d;
            weight_q     <= weight_d;
            image_q      <= image_d;
            tag_row_q    <= tag_row_d;
            tag_col_q    <= tag_col_d;
        end
    end
    assign busy          = busy_q;
    assign done          = done_q;
    assign cfg_err       = cfg_err_q;
    assign w_ready       = w_ready_q;
    assign i_ready       = i_ready_q;
    assign psum_valid    = psum_valid_q;
    assign valid_y       = valid_y_q;
    assign valid_x       = valid_x_q;
    assign weight_val_in = weight_q;
    assign image_val_in  = image_q;
    assign tag_row       = tag_row_q;
    assign tag_col       = tag_col_q;
endmodule

// File: tb/tb_pe_grid_scheduler.sv
// tb_pe_grid_scheduler: randomized job scoreboard against a transaction-level model of the scheduler
module tb_pe_grid_scheduler;
    localparam int DRAIN_CYC = 12;
    typedef struct {
        logic [3:0]  tag;
        logic [15:0] data;
    } beat_t;
    logic        clk, rst, start, busy, done, cfg_err;
    logic [3:0]  cfg_rows, cfg_cols, tag_row, tag_col;
    logic [7:0]  cfg_passes;
    logic        w_valid, w_ready, i_valid, i_ready, valid_y, valid_x, psum_valid, psum_ready;
    logic [15:0] w_data, i_data, weight_val_in, image_val_in;
    beat_t       wq[$], iq[$];
    beat_t       mb;
    int          vectors, miscompares, done_seen, err_seen, exp_done, exp_err;
    pe_grid_scheduler #(.DRAIN_CYC(DRAIN_CYC)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
        .cfg_passes(cfg_passes), .busy(busy), .done(done), .cfg_err(cfg_err),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready),
        .weight_val_in(weight_val_in), .tag_row(tag_row), .valid_y(valid_y),
        .image_val_in(image_val_in), .tag_col(tag_col), .valid_x(valid_x),
        .psum_valid(psum_valid), .psum_ready(psum_ready)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic fail_msg(input string name, input int act, input int exp);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask
    task automatic check_idle(input string name);
        chk(name, {busy, done, cfg_err, w_ready, i_ready, valid_x, valid_y, psum_valid,
                   weight_val_in, image_val_in, tag_row, tag_col}, 64'd0);
    endtask
    // monitor: every presented beat must match the oldest beat the model expects
    always @(negedge clk) begin
        if (valid_y) begin
            if (wq.size() == 0) fail_msg("unexpected valid_y beats", 1, 0);
            else begin
                mb = wq.pop_front();
                chk("tag_row", tag_row, mb.tag);
                chk("weight_val_in", weight_val_in, mb.data);
            end
        end
        if (valid_x) begin
            if (iq.size() == 0) fail_msg("unexpected valid_x beats", 1, 0);
            else begin
                mb = iq.pop_front();
                chk("tag_col", tag_col, mb.tag);
                chk("image_val_in", image_val_in, mb.data);
            end
        end
        if (w_ready && i_ready) fail_msg("w_ready and i_ready both high", 1, 0);
        if (done) done_seen++;
        if (cfg_err) err_seen++;
    end
    task automatic bad_cfg(input int rows, input int cols, input int passes);
        cfg_rows = 4'(rows); cfg_cols = 4'(cols); cfg_passes = 8'(passes); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("cfg_err pulse", cfg_err, 1'b1);
        chk("busy after bad cfg", busy, 1'b0);
        chk("w_ready after bad cfg", w_ready, 1'b0);
        exp_err++;
        @(negedge clk);
        chk("cfg_err one cycle", cfg_err, 1'b0);
    endtask
    // wp<0 selects an alternating 1,0,1,0 weight source
    task automatic run_job(input int rows, input int cols, input int passes, input int wp,
                           input int ip, input bit hold, input int rst_col);
        int n, budget, d, tries;
        bit r;
        cfg_rows = 4'(rows); cfg_cols = 4'(cols); cfg_passes = 8'(passes); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy after start", busy, 1'b1);
        chk("w_ready after start", w_ready, 1'b1);
        n = 0; budget = 0;
        while (n < rows && budget < 2000) begin
            chk("i_ready during weight load", i_ready, 1'b0);
            w_valid = (wp < 0) ? (budget % 2 == 0) : ($urandom_range(99) < wp);
            w_data = 16'($urandom);
            if (w_valid && w_ready) begin
                wq.push_back('{tag: 4'(n), data: w_data});
                n++;
            end
            @(negedge clk);
            budget++;
        end
        w_valid = 1'b0;
        if (n < rows) begin
            fail_msg("weight beats before timeout", n, rows);
            return;
        end
        chk("w_ready drops after last weight", w_ready, 1'b0);
        chk("i_ready after weight load", i_ready, 1'b1);
        for (int p = 0; p < passes; p++) begin
            n = 0; budget = 0;
            while (n < cols && budget < 2000) begin
                if (rst_col >= 0 && n == rst_col + 1) begin
                    rst = 1'b1; i_valid = 1'b1; i_data = 16'($urandom);
                    @(negedge clk);
                    rst = 1'b0; i_valid = 1'b0;
                    check_idle("outputs after mid-job reset");
                    return;
                end
                i_valid = $urandom_range(99) < ip;
                i_data = 16'($urandom);
                if (i_valid && i_ready) begin
                    iq.push_back('{tag: 4'(n), data: i_data});
                    n++;
                end
                @(negedge clk);
                budget++;
            end
            i_valid = 1'b0;
            if (n < cols) begin
                fail_msg("image beats before timeout", n, cols);
                return;
            end
            chk("i_ready drops after last image", i_ready, 1'b0);
            d = 1;
            while (!psum_valid && d < 200) begin
                chk("busy during drain", busy, 1'b1);
                @(negedge clk);
                d++;
            end
            chk("drain length", d, DRAIN_CYC + 1);
            if (hold) begin
                for (int k = 0; k < 5; k++) begin
                    psum_ready = 1'b0;
                    start = (k == 2);
                    @(negedge clk);
                    chk("psum_valid held", psum_valid, 1'b1);
                    chk("no state change while held", {busy, i_ready, w_ready, done}, 4'b1000);
                end
                start = 1'b0;
            end
            tries = 0;
            do begin
                chk("psum_valid before handshake", psum_valid, 1'b1);
                r = 1'($urandom_range(1));
                psum_ready = r;
                @(negedge clk);
                tries++;
            end while (!r && tries < 100);
            psum_ready = 1'b0;
            if (p == passes - 1) begin
                chk("done after last pass", {done, busy, psum_valid}, 3'b100);
                exp_done++;
                @(negedge clk);
                chk("done one cycle", done, 1'b0);
            end else
                chk("next pass after handshake", {i_ready, psum_valid, done, busy}, 4'b1001);
        end
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        vectors = 0; miscompares = 0; done_seen = 0; err_seen = 0; exp_done = 0; exp_err = 0;
        rst = 1'b1; start = 1'b0; cfg_rows = '0; cfg_cols = '0; cfg_passes = '0;
        w_valid = 1'b0; w_data = '0; i_valid = 1'b0; i_data = '0; psum_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("outputs in reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle("outputs after reset");
        run_job(12, 14, 1, 100, 100, 1'b0, -1);
        run_job(4, 3, 1, -1, 100, 1'b0, -1);
        run_job(5, 2, 3, 70, 60, 1'b0, -1);
        bad_cfg(0, 5, 1);
        bad_cfg(3, 15, 1);
        bad_cfg(3, 5, 0);
        bad_cfg(13, 5, 1);
        run_job(3, 4, 2, 80, 80, 1'b1, -1);
        run_job(6, 14, 1, 100, 100, 1'b0, 5);
        run_job(2, 14, 1, 100, 100, 1'b0, -1);
        repeat (6) run_job($urandom_range(12, 1), $urandom_range(14, 1), $urandom_range(3, 1),
                           $urandom_range(100, 40), $urandom_range(100, 40), 1'b0, -1);
        repeat (2) @(negedge clk);
        chk("done pulse count", done_seen, exp_done);
        chk("cfg_err pulse count", err_seen, exp_err);
        chk("pending weight beats", wq.size(), 0);
        chk("pending image beats", iq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pe_grid_scheduler.md
PE_GRID_SCHEDULER -- requirements
Module: pe_grid_scheduler

Interface
REQ-001 Parameter ROWS, default 12, number of PE rows (weight tags 0..ROWS-1).
REQ-002 Parameter COLS, default 14, number of PE columns (image tags 0..COLS-1).
REQ-003 Parameter DATA_W, default 16, weight/image value width.
REQ-004 Parameter ID_W, default 4, tag width.
REQ-005 Parameter DRAIN_CYC, default 12, cycles to wait for vertical psum propagation.
REQ-006 The block SHALL use one clock; reset is synchronous and active-high.
REQ-007 Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  job request.
- cfg_rows  in  ID_W  weight rows to load.
- cfg_cols  in  ID_W  image columns per pass.
- cfg_passes  in  8  image passes per weight load.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.
- cfg_err  out  1  one-cycle illegal-config pulse.
- w_valid / w_data / w_ready  in 1 / in DATA_W / out 1  weight source handshake.
- i_valid / i_data / i_ready  in 1 / in DATA_W / out 1  image source handshake.
- weight_val_in, tag_row, valid_y  out  DATA_W, ID_W, 1  to grid weight router.
- image_val_in, tag_col, valid_x  out  DATA_W, ID_W, 1  to grid image router.
- psum_valid  out  1  grid psum_outs valid for capture.
- psum_ready  in  1  downstream has captured psum_outs.

Function
REQ-008 FSM states SHALL be IDLE, LOAD_W, LOAD_I, DRAIN, OUT.
REQ-009 In IDLE, start with 1<=cfg_rows<=ROWS, 1<=cfg_cols<=COLS, and cfg_passes>=1 SHALL latch all cfg values, clear the counters, and enter LOAD_W next cycle.
REQ-010 In IDLE, start with any other cfg SHALL stay in IDLE and pulse cfg_err for one cycle.
REQ-011 start outside IDLE SHALL be ignored.
REQ-012 busy SHALL be 1 in every state except IDLE.
REQ-013 w_ready SHALL be 1 only in LOAD_W; i_ready SHALL be 1 only in LOAD_I.
REQ-014 Each accepted weight beat (w_valid&w_ready) SHALL drive next cycle: valid_y=1, weight_val_in=w_data, tag_row=row count (0,1,...). Otherwise valid_y=0.
REQ-015 The beat that makes row count equal cfg_rows SHALL move the FSM to LOAD_I in the same edge, and w_ready SHALL drop the following cycle.
REQ-016 Image beats SHALL behave likewise: valid_x=1, image_val_in=i_data, tag_col=col count, one cycle after acceptance.
REQ-017 The last image beat (col count equals cfg_cols) SHALL enter DRAIN with the column counter cleared.
REQ-018 Source bubbles (valid low) SHALL produce valid_x/valid_y=0 cycles and SHALL NOT advance the counters.
REQ-019 DRAIN SHALL last exactly DRAIN_CYC cycles, then enter OUT.
REQ-020 In OUT, psum_valid=1; it SHALL hold until psum_ready=1, and that handshake increments the pass count.
REQ-021 On the OUT handshake, if pass count equals cfg_passes the FSM SHALL pulse done and return to IDLE; otherwise it SHALL return to LOAD_I, keeping the loaded weights.
REQ-022 Counters SHALL never wrap; tag values SHALL never exceed cfg-1.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 rst at any time, including mid-job, SHALL force IDLE next edge.
REQ-025 On rst, every output SHALL go to 0 (busy, done, cfg_err, w_ready, i_ready, valid_x, valid_y, psum_valid, data, tags) and all counters and latched cfg SHALL clear.
REQ-026 Source beats presented during rst SHALL NOT be accepted.

Structure
REQ-027 Shared package pe_grid_pkg SHALL hold ROWS, COLS, DATA_W, ID_W, PSUM_W=32, and the state enum sched_state_t.
REQ-028 One sub-module tag_sequencer (beat counter with limit, tag output, last flag) SHALL be instantiated twice, once for rows and once for columns.

Verification
REQ-029 cfg_rows=12, cfg_cols=14, cfg_passes=1, sources always valid: valid_y on 12 consecutive cycles with tags 0..11 -> 14 valid_x with tags 0..13 -> 12 DRAIN cycles -> psum_valid; psum_ready=1 -> done pulse, busy=0.
REQ-030 cfg_passes=3, cfg_cols=2: one weight load, three image passes with tags 0,1 each, three OUT handshakes, one done.
REQ-031 start with cfg_rows=0, and separately cfg_cols=15: cfg_err pulse, busy stays 0, no valid_x/valid_y.
REQ-032 Alternating w_valid (1,0,1,0...) with cfg_rows=4: valid_y tags 0,1,2,3 separated by 0 cycles, LOAD_I entered after 4th beat only.
REQ-033 psum_ready held 0 for 5 cycles in OUT: psum_valid held, no state change; start pulsed meanwhile is ignored.
REQ-034 rst asserted in LOAD_I after col tag 5: next cycle all outputs 0, IDLE. A new start then runs normally from tag 0.
